// File: rtl/sd_block_sequencer.sv
// sd_block_sequencer
//   Sequences multi-block reads through the SD single-block reader. For each
//   512-byte block it pulses rd_req with rd_addr held, pushes the returned
//   bytes into an internal first-word-fall-through FIFO and streams them out
//   over valid/ready. A block is only issued once the FIFO can take all 512
//   bytes, so a well-behaved reader never overruns it.
//
// Configuration macro: SD_SEQ_LOOP_EN
//   defined   : after NUM_BLOCKS blocks, restart at START_BLOCK until stop.
//   undefined : the pass ends in IDLE after NUM_BLOCKS blocks.
//
// Ports
//   clk_25mhz, rst_n          clock, asynchronous active-low reset
//   start, stop               pass control pulses
//   rd_req, rd_addr           block request to the reader (addr held until done)
//   rd_data, rd_valid, rd_done  byte stream / end-of-block from the reader
//   out_data, out_valid, out_ready  downstream byte stream (FWFT)
//   busy, blocks_done         status
//   err_short, err_ovf        sticky errors (short block, FIFO overflow drop)
module sd_block_sequencer #(
  parameter int unsigned START_BLOCK = 0,
  parameter int unsigned NUM_BLOCKS  = 1024,
  parameter int unsigned ADDR_STEP   = 1,
  parameter int unsigned FIFO_DEPTH  = 1024
) (
  input  logic        clk_25mhz,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic [7:0]  rd_data,
  input  logic        rd_valid,
  input  logic        rd_done,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] blocks_done,
  output logic        err_short,
  output logic        err_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] DEPTH_W   = FW'(FIFO_DEPTH);
  localparam logic [FW-1:0] ROOM_MAX  = FW'(FIFO_DEPTH - 512);
  localparam logic [31:0]   BASE_ADDR = START_BLOCK * ADDR_STEP;

  typedef enum logic [2:0] {S_IDLE, S_ROOM, S_ISSUE, S_READ, S_NEXT} state_t;

  state_t        state_q;
  logic          rd_req_q, busy_q, stop_q, err_short_q, err_ovf_q;
  logic [31:0]   rd_addr_q, blk_cnt_q;
  logic [15:0]   blocks_done_q;
  logic [9:0]    byte_cnt_q, byte_cnt_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [FW-1:0] fill_q, fill_after_pop;
  logic          in_read, push_req, push, pop, full, drop, room;

  // ---------------- FIFO ----------------
  assign in_read  = (state_q == S_READ);
  assign full     = (fill_q == DEPTH_W);
  assign pop      = (fill_q != '0) && out_ready;
  assign push_req = in_read && rd_valid;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Room test looks at the fill level after this cycle's pop.
  assign fill_after_pop = fill_q - FW'(pop);
  assign room           = (fill_after_pop <= ROOM_MAX);

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      fill_q <= fill_q + FW'(push) - FW'(pop);
    end
  end

  // Storage is not reset; only pointers and fill define contents.
  always_ff @(posedge clk_25mhz) begin
    if (push) mem_q[wptr_q] <= rd_data;
  end

  assign out_valid = (fill_q != '0);
  assign out_data  = out_valid ? mem_q[rptr_q] : 8'h00;

  // Byte count including a same-cycle byte, saturating at 1023.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (push_req && byte_cnt_q != 10'h3FF) byte_cnt_d = byte_cnt_q + 10'd1;
  end

  // ---------------- sequencer FSM ----------------
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rd_req_q      <= 1'b0;
      busy_q        <= 1'b0;
      stop_q        <= 1'b0;
      rd_addr_q     <= '0;
      blk_cnt_q     <= '0;
      blocks_done_q <= '0;
      byte_cnt_q    <= '0;
      err_short_q   <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      // Latch stop while busy; any transition to IDLE below clears it.
      if (stop && state_q != S_IDLE) stop_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rd_addr_q     <= BASE_ADDR;
            blk_cnt_q     <= '0;
            blocks_done_q <= '0;
            err_short_q   <= 1'b0;
            err_ovf_q     <= 1'b0;
            stop_q        <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= S_ROOM;
          end
        end
        S_ROOM: begin
          if (stop || stop_q) begin
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (room) begin
            rd_req_q <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rd_req_q   <= 1'b0;
          byte_cnt_q <= '0;
          state_q    <= S_READ;
        end
        S_READ: begin
          byte_cnt_q <= byte_cnt_d;
          if (drop) err_ovf_q <= 1'b1;
          if (rd_done) begin
            if (byte_cnt_d != 10'd512) err_short_q <= 1'b1;
            blocks_done_q <= blocks_done_q + 16'd1;
            blk_cnt_q     <= blk_cnt_q + 32'd1;
            state_q       <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (stop || stop_q) begin
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (blk_cnt_q == NUM_BLOCKS) begin
`ifdef SD_SEQ_LOOP_EN
            blk_cnt_q <= '0;
            rd_addr_q <= BASE_ADDR;
            state_q   <= S_ROOM;
`else
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`endif
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_STEP;
            state_q   <= S_ROOM;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign busy        = busy_q;
  assign blocks_done = blocks_done_q;
  assign err_short   = err_short_q;
  assign err_ovf     = err_ovf_q;

endmodule
